// File: rtl/einstein_pkg.sv
// ============================================================================
//  Module  : einstein_pkg
//  Purpose : Shared types and constants for the ioctl upload reader:
//            controller state encoding, byte-FIFO depth, pointer widths and
//            a saturating-increment helper.
//  Ports   : (package - none)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package einstein_pkg;

  // Upload controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_READ  = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Host-side byte buffer depth and its occupancy-counter width
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = 2;

  // Fetch pointer / byte counter width
  localparam int PTR_W = 17;

  // Byte presented when no data is available or past the end of the image
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  // Increment that sticks at lim once reached
  function automatic logic [PTR_W-1:0] sat_inc17(input logic [PTR_W-1:0] v,
                                                 input logic [PTR_W-1:0] lim);
    return (v < lim) ? v + 17'd1 : lim;
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_fifo2.sv
// ============================================================================
//  Module  : byte_fifo2
//  Purpose : Two-entry byte FIFO. A push and a pop in the same cycle both
//            take effect even when full, leaving occupancy unchanged.
//  Ports   : clk_sys      - clock (rising edge)
//            reset        - synchronous active-high reset
//            clr_i        - synchronous flush (empties the FIFO)
//            push_i       - write push_data_i
//            push_data_i  - byte to write
//            pop_i        - discard head (ignored when empty)
//            full_o       - both entries occupied
//            empty_o      - no entries occupied
//            head_o       - oldest entry (undefined contents when empty)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module byte_fifo2
  import einstein_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam logic [FIFO_CNT_W-1:0] DEPTH_CNT = FIFO_CNT_W'(FIFO_DEPTH);

  logic [7:0]            mem_q [FIFO_DEPTH];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [FIFO_CNT_W-1:0] cnt_q;

  logic w_do_pop;
  logic w_do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH_CNT);
  assign head_o  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a full-FIFO push needs
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_ff @(posedge clk_sys) begin
    if (reset || clr_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= ~wr_ptr_q;
      if (w_do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({w_do_push, w_do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy decides what is visible
  always_ff @(posedge clk_sys) begin
    if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/ioctl_upload_reader.sv
// ============================================================================
//  Module  : ioctl_upload_reader
//  Purpose : Streams a RAM image from SDRAM to the host ioctl upload port.
//            Fetches bytes through the CPU-side arbiter into a 2-entry FIFO;
//            bytes at or beyond SIZE are served as 8'hFF without SDRAM access.
//  Ports   : clk_sys      - clock (rising edge)
//            reset        - synchronous active-high reset
//            ioctl_upload - upload session active (level)
//            ioctl_rd     - host consumed ioctl_din, wants next byte (pulse)
//            ioctl_din    - byte presented to host (FF when buffer empty)
//            mem_req      - SDRAM ownership request to arbiter
//            mem_gnt      - arbiter grant (level)
//            mem_addr     - SDRAM byte address
//            mem_rd       - read command, held until mem_ready
//            mem_dout     - SDRAM read data, valid with mem_ready
//            mem_ready    - read-completion pulse
//            underrun     - sticky: host read with buffer empty
//            byte_count   - bytes consumed by host this session (saturating)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ioctl_upload_reader
  import einstein_pkg::*;
#(
  parameter logic [22:0] BASE_ADDR = 23'h010000,
  parameter int          SIZE      = 65536
)(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  output logic [7:0]  ioctl_din,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [22:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_dout,
  input  logic        mem_ready,
  output logic        underrun,
  output logic [16:0] byte_count
);

  localparam logic [PTR_W-1:0] SIZE_LIM  = PTR_W'(SIZE);
  localparam logic [PTR_W-1:0] COUNT_MAX = 17'h1FFFF;

  state_e           state_q,    state_d;
  logic             upload_q;
  logic             abort_q,    abort_d;
  logic             have_q,     have_d;
  logic [7:0]       data_q,     data_d;
  logic [PTR_W-1:0] ptr_q,      ptr_d;
  logic [PTR_W-1:0] count_q,    count_d;
  logic             underrun_q, underrun_d;

  logic       w_start;
  logic       w_fall;
  logic       w_push;
  logic [7:0] w_push_data;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_head;

  // Session start only recognised in IDLE; a drop is seen in any state
  assign w_start = (state_q == ST_IDLE) && ioctl_upload && !upload_q;
  assign w_fall  = upload_q && !ioctl_upload;

  byte_fifo2 u_fifo (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .clr_i       (w_start),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (ioctl_rd),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .head_o      (w_head)
  );

  assign ioctl_din  = w_empty ? FILL_BYTE : w_head;
  assign underrun   = underrun_q;
  assign byte_count = count_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      upload_q   <= 1'b0;
      abort_q    <= 1'b0;
      have_q     <= 1'b0;
      data_q     <= FILL_BYTE;
      ptr_q      <= '0;
      count_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      upload_q   <= ioctl_upload;
      abort_q    <= abort_d;
      have_q     <= have_d;
      data_q     <= data_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      underrun_q <= underrun_d;
    end
  end

  // Host-side accounting: every ioctl_rd counts, even into an empty buffer
  always_comb begin
    count_d    = count_q;
    underrun_d = underrun_q;
    if (w_start) begin
      count_d    = '0;
      underrun_d = 1'b0;
    end else if (ioctl_rd) begin
      count_d = sat_inc17(count_q, COUNT_MAX);
      if (w_empty) underrun_d = 1'b1;
    end
  end

  // Fetch controller
  always_comb begin
    state_d     = state_q;
    abort_d     = abort_q;
    have_d      = have_q;
    data_d      = data_q;
    ptr_d       = ptr_q;
    w_push      = 1'b0;
    w_push_data = data_q;
    mem_req     = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        have_d  = 1'b0;
        if (w_start) begin
          ptr_d   = '0;
          state_d = (SIZE_LIM == '0) ? ST_STORE : ST_ARB;
        end
      end

      ST_ARB: begin
        mem_req  = 1'b1;
        mem_addr = BASE_ADDR + {6'd0, ptr_q};
        if (w_fall)       state_d = ST_DONE;
        else if (mem_gnt) state_d = ST_READ;
      end

      ST_READ: begin
        // Grant loss does not cancel an issued read; a drop of the upload
        // is remembered and acted on once the read completes.
        mem_req  = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = BASE_ADDR + {6'd0, ptr_q};
        if (w_fall) abort_d = 1'b1;
        if (mem_ready) begin
          if (abort_q || w_fall) begin
            state_d = ST_DONE;
          end else begin
            data_d  = mem_dout;
            have_d  = 1'b1;
            state_d = ST_STORE;
          end
        end
      end

      ST_STORE: begin
        if (w_fall) begin
          have_d  = 1'b0;
          state_d = ST_DONE;
        end else if (have_q) begin
          // Place the fetched byte; a same-cycle pop makes room when full
          if (!w_full || ioctl_rd) begin
            w_push = 1'b1;
            have_d = 1'b0;
            ptr_d  = sat_inc17(ptr_q, SIZE_LIM);
          end
        end else if (ptr_q < SIZE_LIM) begin
          if (!w_full) state_d = ST_ARB;
        end else begin
          // Past the image: fill with FF locally, no SDRAM traffic
          if (!w_full || ioctl_rd) begin
            w_push      = 1'b1;
            w_push_data = FILL_BYTE;
          end
        end
      end

      ST_DONE: begin
        abort_d = 1'b0;
        have_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire
